adpll_loop_ctrl: RTL and testbench

ADPLL_LOOP_CTRL -- requirements
Module: adpll_loop_ctrl

---
 rtl/adpll_pkg.sv | 25 ++
 rtl/adpll_lock_det.sv | 83 ++++++++
 rtl/adpll_loop_ctrl.sv | 127 ++++++++++++
 tb/tb_adpll_loop_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// ADPLL loop controller shared types: FSM state and PFD sample class.
package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAR    = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_e;

  // HOLD doubles as "no direction seen yet" in the last-direction register.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2
  } cls_e;

  // UP means feedback is slow (raise the code); both or neither means hold.
  function automatic cls_e classify(input logic up, input logic dn);
    if (up && !dn) return INC;
    if (dn && !up) return DEC;
    return HOLD;
  endfunction

endpackage

// File: rtl/adpll_lock_det.sv
// Settle / lock-loss counter for the ADPLL loop controller.
// Optional lock-loss detection is compiled in with ADPLL_LOCK_LOSS_EN.
module adpll_lock_det
  import adpll_pkg::*;
#(
  parameter int LOCK_CNT = 8
`ifdef ADPLL_LOCK_LOSS_EN
  , parameter int LOSS_CNT = 4
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,     // drop all history (not tracking, restart, disable)
  input  logic vld_i,     // qualified sample this cycle
  input  cls_e cls_i,
`ifdef ADPLL_LOCK_LOSS_EN
  input  logic locked_i,
  output logic loss_o,
`endif
  output logic settled_o
);

  localparam int SW = $clog2(LOCK_CNT + 1);
  localparam logic [SW-1:0] LOCK_MAX = SW'(LOCK_CNT);

  logic [SW-1:0] settle_q, settle_d;
  cls_e          last_q, last_d;

`ifdef ADPLL_LOCK_LOSS_EN
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_CNT);
  logic [LW-1:0] loss_q, loss_d;
`endif

  // Next-state for settle run, last direction and (optionally) loss run.
  always_comb begin
    settle_d  = settle_q;
    last_d    = last_q;
    settled_o = 1'b0;
    if (vld_i) begin
      if (cls_i == HOLD || (last_q != HOLD && cls_i != last_q))
        settle_d = (settle_q == LOCK_MAX) ? settle_q : settle_q + 1'b1;
      else if (cls_i == last_q)
        settle_d = '0;
      if (cls_i != HOLD) last_d = cls_i;
      settled_o = (settle_d == LOCK_MAX);
    end
`ifdef ADPLL_LOCK_LOSS_EN
    loss_d = loss_q;
    loss_o = 1'b0;
    if (!locked_i) begin
      loss_d = '0;
    end else if (vld_i) begin
      if (cls_i == HOLD)        loss_d = '0;
      else if (cls_i == last_q) loss_d = (loss_q == LOSS_MAX) ? loss_q : loss_q + 1'b1;
      else                      loss_d = LW'(1);
      if (loss_d == LOSS_MAX) begin
        loss_o   = 1'b1;
        loss_d   = '0;
        settle_d = '0;
      end
    end
`endif
  end

  // History registers; cleared on reset or whenever the loop is not tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      settle_q <= '0;
      last_q   <= HOLD;
`ifdef ADPLL_LOCK_LOSS_EN
      loss_q   <= '0;
`endif
    end else begin
      settle_q <= settle_d;
      last_q   <= last_d;
`ifdef ADPLL_LOCK_LOSS_EN
      loss_q   <= loss_d;
`endif
    end
  end

endmodule

// File: rtl/adpll_loop_ctrl.sv
// ADPLL loop controller: SAR coarse search of the DCO code, then +/-1
// tracking with lock detection. ADPLL_LOCK_LOSS_EN adds lock-loss exit.
module adpll_loop_ctrl
  import adpll_pkg::*;
#(
  parameter int CODE_W   = 7,
  parameter int DIV_W    = 3,
  parameter int LOCK_CNT = 8
`ifdef ADPLL_LOCK_LOSS_EN
  , parameter int LOSS_CNT = 4
`endif
) (
  input  logic              REF_CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic [DIV_W-1:0]  M,
  input  logic              CMP_VALID,
  input  logic              UP,
  input  logic              DN,
  output logic [CODE_W-1:0] DCO_CODE,
  output logic              LOCK,
  output logic [1:0]        STATE,
  output logic [DIV_W-1:0]  FREQ_DIV
);

  localparam int KW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam logic [CODE_W-1:0] MID   = CODE_W'(1) << (CODE_W - 1);
  localparam logic [CODE_W-1:0] MAXC  = '1;
  localparam logic [KW-1:0]     K_TOP = KW'(CODE_W - 1);

  state_e            state_q;
  logic [CODE_W-1:0] code_q, sar_code, trk_code;
  logic [KW-1:0]     k_q;
  logic [DIV_W-1:0]  m_q;
  logic              lock_q;

  cls_e cls;
  logic tracking, m_chg, det_clr, det_vld, settled;
`ifdef ADPLL_LOCK_LOSS_EN
  logic loss;
`endif

  assign cls      = classify(UP, DN);
  assign tracking = (state_q == TRACK) || (state_q == LOCKED);
  assign m_chg    = (state_q != IDLE) && (M != m_q);
  assign det_clr  = !EN || m_chg || !tracking;
  assign det_vld  = CMP_VALID && tracking && EN && !m_chg;

  // Candidate codes: SAR bit decision and saturating tracking step.
  always_comb begin
    sar_code = code_q;
    if (cls == DEC) sar_code[k_q] = 1'b0;
    if (k_q != '0)  sar_code[k_q - KW'(1)] = 1'b1;
    trk_code = code_q;
    if (cls == INC && code_q != MAXC) trk_code = code_q + 1'b1;
    if (cls == DEC && code_q != '0)   trk_code = code_q - 1'b1;
  end

  adpll_lock_det #(
    .LOCK_CNT (LOCK_CNT)
`ifdef ADPLL_LOCK_LOSS_EN
    , .LOSS_CNT (LOSS_CNT)
`endif
  ) u_lock_det (
    .clk_i     (REF_CLK),
    .rst_i     (RESET),
    .clr_i     (det_clr),
    .vld_i     (det_vld),
    .cls_i     (cls),
`ifdef ADPLL_LOCK_LOSS_EN
    .locked_i  (state_q == LOCKED),
    .loss_o    (loss),
`endif
    .settled_o (settled)
  );

  // Loop FSM; priority RESET > EN=0 > M change > sample.
  always_ff @(posedge REF_CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      code_q  <= MID;
      k_q     <= K_TOP;
      m_q     <= '0;
      lock_q  <= 1'b0;
    end else if (!EN) begin
      state_q <= IDLE;
      lock_q  <= 1'b0;
    end else if (state_q == IDLE || m_chg) begin
      state_q <= SAR;
      code_q  <= MID;
      k_q     <= K_TOP;
      m_q     <= M;
      lock_q  <= 1'b0;
    end else if (CMP_VALID) begin
      case (state_q)
        SAR: begin
          code_q <= sar_code;
          if (k_q != '0) k_q <= k_q - KW'(1);
          else           state_q <= TRACK;
        end
        TRACK: begin
          code_q <= trk_code;
          if (settled) begin
            state_q <= LOCKED;
            lock_q  <= 1'b1;
          end
        end
        LOCKED: begin
          code_q <= trk_code;
`ifdef ADPLL_LOCK_LOSS_EN
          if (loss) begin
            state_q <= TRACK;
            lock_q  <= 1'b0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign DCO_CODE = code_q;
  assign LOCK     = lock_q;
  assign STATE    = state_q;
  assign FREQ_DIV = M;

endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// Directed bench for adpll_loop_ctrl (default parameters).
module tb_adpll_loop_ctrl;

  logic       REF_CLK = 1'b0;
  logic       RESET, EN, CMP_VALID, UP, DN;
  logic [2:0] M;
  logic [6:0] DCO_CODE;
  logic       LOCK;
  logic [1:0] STATE;
  logic [2:0] FREQ_DIV;

  int n_cmp = 0;
  int n_err = 0;

  adpll_loop_ctrl dut (
    .REF_CLK   (REF_CLK),
    .RESET     (RESET),
    .EN        (EN),
    .M         (M),
    .CMP_VALID (CMP_VALID),
    .UP        (UP),
    .DN        (DN),
    .DCO_CODE  (DCO_CODE),
    .LOCK      (LOCK),
    .STATE     (STATE),
    .FREQ_DIV  (FREQ_DIV)
  );

  always #5 REF_CLK = ~REF_CLK;

  // One-cycle PFD strobe; returns on the negedge after the consuming edge.
  task automatic sample(input logic up, input logic dn);
    CMP_VALID = 1'b1; UP = up; DN = dn;
    @(negedge REF_CLK);
    CMP_VALID = 1'b0; UP = 1'b0; DN = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; EN = 1'b0; M = 3'd3; CMP_VALID = 1'b1; UP = 1'b1; DN = 1'b0;
    @(negedge REF_CLK);
    @(negedge REF_CLK);
    RESET = 1'b0; CMP_VALID = 1'b0; UP = 1'b0;
    n_cmp++; if (DCO_CODE !== 7'd64) begin n_err++; $display("FAIL reset_code got %0d exp 64", DCO_CODE); end
    n_cmp++; if (LOCK !== 1'b0)      begin n_err++; $display("FAIL reset_lock got %0b exp 0", LOCK); end
    n_cmp++; if (STATE !== 2'd0)     begin n_err++; $display("FAIL reset_state got %0d exp 0", STATE); end
    n_cmp++; if (FREQ_DIV !== 3'd3)  begin n_err++; $display("FAIL freq_div got %0d exp 3", FREQ_DIV); end
    @(negedge REF_CLK);
    n_cmp++; if (STATE !== 2'd0)     begin n_err++; $display("FAIL idle_hold got %0d exp 0", STATE); end
  endtask

  task automatic test_sar();
    logic [6:0] exp_c [7];
    logic       up_v  [7];
    logic       dn_v  [7];
    exp_c = '{7'd96, 7'd80, 7'd88, 7'd92, 7'd94, 7'd93, 7'd93};
    up_v  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    dn_v  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    EN = 1'b1;
    @(negedge REF_CLK);
    n_cmp++; if (STATE !== 2'd1)     begin n_err++; $display("FAIL sar_enter got %0d exp 1", STATE); end
    n_cmp++; if (DCO_CODE !== 7'd64) begin n_err++; $display("FAIL sar_mid got %0d exp 64", DCO_CODE); end
    for (int i = 0; i < 7; i++) begin
      sample(up_v[i], dn_v[i]);
      n_cmp++;
      if (DCO_CODE !== exp_c[i]) begin
        n_err++; $display("FAIL sar_step%0d got %0d exp %0d", i, DCO_CODE, exp_c[i]);
      end
    end
    n_cmp++; if (STATE !== 2'd2) begin n_err++; $display("FAIL sar_done got %0d exp 2", STATE); end
    repeat (3) @(negedge REF_CLK);
    n_cmp++; if (DCO_CODE !== 7'd93) begin n_err++; $display("FAIL no_strobe got %0d exp 93", DCO_CODE); end
  endtask

  task automatic test_sat_lock();
    RESET = 1'b1;
    @(negedge REF_CLK);
    RESET = 1'b0;
    @(negedge REF_CLK);
    for (int i = 0; i < 7; i++) sample(1'b1, 1'b0);
    n_cmp++; if (DCO_CODE !== 7'd127) begin n_err++; $display("FAIL sar_all_inc got %0d exp 127", DCO_CODE); end
    n_cmp++; if (STATE !== 2'd2)      begin n_err++; $display("FAIL track_enter got %0d exp 2", STATE); end
    sample(1'b1, 1'b0);
    n_cmp++; if (DCO_CODE !== 7'd127) begin n_err++; $display("FAIL sat_high got %0d exp 127", DCO_CODE); end
    for (int i = 0; i < 8; i++) begin
      sample((i % 2) == 1, (i % 2) == 0);
      if (i == 0) begin
        n_cmp++; if (DCO_CODE !== 7'd126) begin n_err++; $display("FAIL trk_dec got %0d exp 126", DCO_CODE); end
      end
      if (i == 6) begin
        n_cmp++; if (LOCK !== 1'b0) begin n_err++; $display("FAIL early_lock got %0b exp 0", LOCK); end
      end
    end
    n_cmp++; if (LOCK !== 1'b1)       begin n_err++; $display("FAIL lock got %0b exp 1", LOCK); end
    n_cmp++; if (STATE !== 2'd3)      begin n_err++; $display("FAIL locked_state got %0d exp 3", STATE); end
    n_cmp++; if (DCO_CODE !== 7'd127) begin n_err++; $display("FAIL lock_code got %0d exp 127", DCO_CODE); end
  endtask

  task automatic test_lock_loss();
    for (int i = 0; i < 3; i++) sample(1'b1, 1'b0);
    n_cmp++; if (LOCK !== 1'b1) begin n_err++; $display("FAIL loss_early got %0b exp 1", LOCK); end
    sample(1'b1, 1'b0);
`ifdef ADPLL_LOCK_LOSS_EN
    n_cmp++; if (LOCK !== 1'b0)  begin n_err++; $display("FAIL loss_lock got %0b exp 0", LOCK); end
    n_cmp++; if (STATE !== 2'd2) begin n_err++; $display("FAIL loss_state got %0d exp 2", STATE); end
`else
    n_cmp++; if (LOCK !== 1'b1)  begin n_err++; $display("FAIL sticky_lock got %0b exp 1", LOCK); end
    n_cmp++; if (STATE !== 2'd3) begin n_err++; $display("FAIL sticky_state got %0d exp 3", STATE); end
`endif
    n_cmp++; if (DCO_CODE !== 7'd127) begin n_err++; $display("FAIL loss_code got %0d exp 127", DCO_CODE); end
  endtask

  task automatic test_restart();
    M = 3'd5;
    @(negedge REF_CLK);
    n_cmp++; if (DCO_CODE !== 7'd64) begin n_err++; $display("FAIL restart_code got %0d exp 64", DCO_CODE); end
    n_cmp++; if (STATE !== 2'd1)     begin n_err++; $display("FAIL restart_state got %0d exp 1", STATE); end
    n_cmp++; if (LOCK !== 1'b0)      begin n_err++; $display("FAIL restart_lock got %0b exp 0", LOCK); end
    n_cmp++; if (FREQ_DIV !== 3'd5)  begin n_err++; $display("FAIL restart_div got %0d exp 5", FREQ_DIV); end
  endtask

  task automatic test_sat_low();
    for (int i = 0; i < 7; i++) sample(1'b0, 1'b1);
    n_cmp++; if (DCO_CODE !== 7'd0) begin n_err++; $display("FAIL sar_all_dec got %0d exp 0", DCO_CODE); end
    n_cmp++; if (STATE !== 2'd2)    begin n_err++; $display("FAIL low_track got %0d exp 2", STATE); end
    sample(1'b0, 1'b1);
    n_cmp++; if (DCO_CODE !== 7'd0) begin n_err++; $display("FAIL sat_low got %0d exp 0", DCO_CODE); end
    sample(1'b1, 1'b0);
    n_cmp++; if (DCO_CODE !== 7'd1) begin n_err++; $display("FAIL low_inc got %0d exp 1", DCO_CODE); end
  endtask

  task automatic test_priority();
    M = 3'd3;
    @(negedge REF_CLK);
    sample(1'b1, 1'b0);
    n_cmp++; if (DCO_CODE !== 7'd96) begin n_err++; $display("FAIL prio_sar got %0d exp 96", DCO_CODE); end
    EN = 1'b0; M = 3'd6;
    sample(1'b1, 1'b0);
    n_cmp++; if (STATE !== 2'd0)     begin n_err++; $display("FAIL en_off_state got %0d exp 0", STATE); end
    n_cmp++; if (DCO_CODE !== 7'd96) begin n_err++; $display("FAIL en_off_code got %0d exp 96", DCO_CODE); end
    sample(1'b0, 1'b1);
    n_cmp++; if (DCO_CODE !== 7'd96) begin n_err++; $display("FAIL idle_code got %0d exp 96", DCO_CODE); end
    EN = 1'b1;
    @(negedge REF_CLK);
    sample(1'b1, 1'b0);
    n_cmp++; if (DCO_CODE !== 7'd96) begin n_err++; $display("FAIL reen_sar got %0d exp 96", DCO_CODE); end
    RESET = 1'b1;
    sample(1'b0, 1'b1);
    RESET = 1'b0; EN = 1'b0;
    n_cmp++; if (DCO_CODE !== 7'd64) begin n_err++; $display("FAIL rst_sar_code got %0d exp 64", DCO_CODE); end
    n_cmp++; if (STATE !== 2'd0)     begin n_err++; $display("FAIL rst_sar_state got %0d exp 0", STATE); end
    n_cmp++; if (LOCK !== 1'b0)      begin n_err++; $display("FAIL rst_sar_lock got %0b exp 0", LOCK); end
  endtask

  initial begin
    RESET = 1'b1; EN = 1'b0; M = 3'd3; CMP_VALID = 1'b0; UP = 1'b0; DN = 1'b0;
    test_reset();
    test_sar();
    test_sat_lock();
    test_lock_loss();
    test_restart();
    test_sat_low();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
